// File: rtl/interrupt_controller_if.sv
// Interrupt controller bus interface.
// Bundles the request lines, the CPU control strobes and the controller status outputs.
//   master : the CPU/system side.
//            Drives interruptions, mask_we, mask_in, int_ack, int_end and lost_clr.
//            Observes int_req, int_vector, in_service, pending and lost.
//   slave  : the interrupt controller itself, with the opposite directions.
interface interrupt_controller_if #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
);
    logic [NUM_IRQ-1:0] interruptions;
    logic               mask_we;
    logic [NUM_IRQ-1:0] mask_in;
    logic               int_ack;
    logic               int_end;
    logic               lost_clr;
    logic               int_req;
    logic [VEC_W-1:0]   int_vector;
    logic               in_service;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] lost;

    modport master (
        output interruptions, mask_we, mask_in, int_ack, int_end, lost_clr,
        input  int_req, int_vector, in_service, pending, lost
    );

    modport slave (
        input  interruptions, mask_we, mask_in, int_ack, int_end, lost_clr,
        output int_req, int_vector, in_service, pending, lost
    );
endinterface

// File: rtl/interrupt_controller.sv
// Edge-triggered, fixed-priority interrupt controller with a single service level.
//
// Each line's rising edge latches a pending bit. The lowest-numbered pending line
// that is also unmasked is requested from the CPU. The request is acknowledged
// with int_ack and the handler is closed with int_end. An edge that arrives while
// its line is still pending sets a sticky lost flag.
//
// Ports
//   clk   : system clock; all state changes on its rising edge.
//   reset : asynchronous, active-low reset.
//   bus   : slave side of interrupt_controller_if.
//           Inputs:  request lines, mask write, ack/end pulses, lost clear.
//           Outputs: int_req, int_vector, in_service, pending, lost.
module interrupt_controller #(
    parameter int NUM_IRQ = 8,
    parameter int VEC_W   = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

    state_t             state;
    logic               req_q;
    logic [VEC_W-1:0]   vec_q;
    logic               svc_q;
    logic [NUM_IRQ-1:0] prev;
    logic [NUM_IRQ-1:0] mask;
    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] lost_q;

    logic [NUM_IRQ-1:0] edge_det;
    logic [NUM_IRQ-1:0] ack_clr;
    logic [NUM_IRQ-1:0] sel;
    logic [NUM_IRQ-1:0] one_hot;
    logic [VEC_W-1:0]   sel_idx;

    assign edge_det = bus.interruptions & ~prev;
    assign sel      = pend_q & mask;
    assign one_hot  = {{(NUM_IRQ-1){1'b0}}, 1'b1} << vec_q;
    // The ack clears only the line being serviced, and only in REQUEST.
    assign ack_clr  = (state == REQUEST && bus.int_ack) ? one_hot : '0;

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        sel_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = VEC_W'(i);
        end
    end

    // Per-line edge capture, pending and lost bookkeeping.
    // A new edge beats both the ack clear and lost_clr in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev   <= '0;
            mask   <= '1;
            pend_q <= '0;
            lost_q <= '0;
        end else begin
            prev   <= bus.interruptions;
            if (bus.mask_we) mask <= bus.mask_in;
            pend_q <= edge_det | (pend_q & ~ack_clr);
            lost_q <= (edge_det & pend_q & ~ack_clr) | (lost_q & ~{NUM_IRQ{bus.lost_clr}});
        end
    end

    // Request/service sequencing. The vector is frozen from the IDLE->REQUEST
    // edge until the next request, so later arrivals or mask writes cannot retarget it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            req_q <= 1'b0;
            vec_q <= '0;
            svc_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (|sel) begin
                    state <= REQUEST;
                    req_q <= 1'b1;
                    vec_q <= sel_idx;
                end
                REQUEST: if (bus.int_ack) begin
                    state <= SERVICE;
                    req_q <= 1'b0;
                    svc_q <= 1'b1;
                end
                SERVICE: if (bus.int_end) begin
                    state <= IDLE;
                    svc_q <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    req_q <= 1'b0;
                    svc_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.int_req    = req_q;
    assign bus.int_vector = vec_q;
    assign bus.in_service = svc_q;
    assign bus.pending    = pend_q;
    assign bus.lost       = lost_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed testbench for interrupt_controller.
// Inputs change 1 time unit after a rising edge; outputs are checked at the same point.
module tb_interrupt_controller;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    interrupt_controller_if #(.NUM_IRQ(8), .VEC_W(3)) bus ();

    interrupt_controller #(.NUM_IRQ(8), .VEC_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset             = 1'b0;
        bus.interruptions = '0;
        bus.mask_we       = 1'b0;
        bus.mask_in       = '0;
        bus.int_ack       = 1'b0;
        bus.int_end       = 1'b0;
        bus.lost_clr      = 1'b0;
        #3;
        check("rst_req", bus.int_req, 0);
        check("rst_vec", bus.int_vector, 0);
        check("rst_svc", bus.in_service, 0);
        check("rst_pend", bus.pending, 0);
        check("rst_lost", bus.lost, 0);
        tick();
        reset = 1'b1;
        tick();

        // Single pulse on line 3.
        bus.interruptions = 8'h08; tick(); bus.interruptions = 8'h00;
        check("p3_pend", bus.pending, 8'h08);
        check("p3_req_k", bus.int_req, 0);
        tick();
        check("p3_req", bus.int_req, 1);
        check("p3_vec", bus.int_vector, 3);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        check("p3_ack_pend", bus.pending, 0);
        check("p3_ack_svc", bus.in_service, 1);
        check("p3_ack_req", bus.int_req, 0);
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;
        check("p3_end_svc", bus.in_service, 0);
        check("p3_end_vec", bus.int_vector, 3);
        tick();
        check("p3_idle_req", bus.int_req, 0);

        // Lines 5 and 1 together: line 1 is served first.
        bus.interruptions = 8'h22; tick(); bus.interruptions = 8'h00;
        check("p51_pend", bus.pending, 8'h22);
        tick();
        check("p51_vec1", bus.int_vector, 1);
        check("p51_req1", bus.int_req, 1);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        check("p51_pend_mid", bus.pending, 8'h20);
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;
        check("p51_pend_end", bus.pending, 8'h20);
        tick();
        check("p51_req2", bus.int_req, 1);
        check("p51_vec2", bus.int_vector, 5);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;
        check("p51_pend_done", bus.pending, 0);

        // A masked line is latched but not requested.
        bus.mask_we = 1'b1; bus.mask_in = 8'hFE; tick(); bus.mask_we = 1'b0;
        bus.interruptions = 8'h01; tick(); bus.interruptions = 8'h00;
        check("m0_pend", bus.pending, 8'h01);
        tick();
        check("m0_req_masked", bus.int_req, 0);
        bus.mask_we = 1'b1; bus.mask_in = 8'hFF; tick(); bus.mask_we = 1'b0;
        check("m0_req_wr", bus.int_req, 0);
        tick();
        check("m0_req", bus.int_req, 1);
        check("m0_vec", bus.int_vector, 0);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;

        // Lost flag and set-beats-clear behaviour on line 2.
        bus.interruptions = 8'h04; tick(); bus.interruptions = 8'h00;
        tick();
        check("l2_req", bus.int_req, 1);
        check("l2_vec", bus.int_vector, 2);
        bus.interruptions = 8'h04; tick(); bus.interruptions = 8'h00;
        check("l2_lost", bus.lost, 8'h04);
        bus.mask_we = 1'b1; bus.mask_in = 8'h00; tick(); bus.mask_we = 1'b0;
        check("l2_frozen_req", bus.int_req, 1);
        bus.mask_in = 8'hFF; bus.mask_we = 1'b1;
        bus.lost_clr = 1'b1; tick(); bus.lost_clr = 1'b0; bus.mask_we = 1'b0;
        check("l2_lost_clr", bus.lost, 0);
        bus.interruptions = 8'h04; bus.int_ack = 1'b1; tick();
        bus.interruptions = 8'h00; bus.int_ack = 1'b0;
        check("l2_set_wins_pend", bus.pending, 8'h04);
        check("l2_set_wins_lost", bus.lost, 0);
        check("l2_svc", bus.in_service, 1);
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;
        tick();
        check("l2_rereq_vec", bus.int_vector, 2);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;
        check("l2_rereq_pend", bus.pending, 0);

        // In SERVICE: no nesting; a new lost event beats lost_clr.
        bus.interruptions = 8'h01; tick(); bus.interruptions = 8'h00;
        tick();
        check("svc_no_nest", bus.int_req, 0);
        bus.interruptions = 8'h01; bus.lost_clr = 1'b1; tick();
        bus.interruptions = 8'h00; bus.lost_clr = 1'b0;
        check("lost_beats_clr", bus.lost, 8'h01);
        bus.lost_clr = 1'b1; tick(); bus.lost_clr = 1'b0;
        check("lost_clr2", bus.lost, 0);
        bus.int_end = 1'b1; tick(); bus.int_end = 1'b0;
        tick();
        check("s0_vec", bus.int_vector, 0);
        bus.int_ack = 1'b1; tick(); bus.int_ack = 1'b0;

        // Reset during SERVICE with line 4 pending, and line 4 held high at release.
        bus.interruptions = 8'h10; tick(); bus.interruptions = 8'h00;
        check("r_pend", bus.pending, 8'h10);
        check("r_svc_pre", bus.in_service, 1);
        #2;
        reset = 1'b0;
        #1;
        check("r_async_svc", bus.in_service, 0);
        check("r_async_pend", bus.pending, 0);
        check("r_async_vec", bus.int_vector, 0);
        check("r_async_req", bus.int_req, 0);
        bus.interruptions = 8'h10;
        tick();
        reset = 1'b1;
        tick();
        check("r_rel_pend", bus.pending, 8'h10);
        tick();
        check("r_rel_req", bus.int_req, 1);
        check("r_rel_vec", bus.int_vector, 4);
        check("r_level_lost", bus.lost, 0);
        bus.interruptions = 8'h00;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
